trap_seq_ctrl: RTL and testbench
================================

Name: trap_seq_ctrl

Overview:
- Multi-cycle trap/return sequencer between the decode stage and the CSR file.
- Consumes decode flags (ecall, ebreak, mret, unknown/illegal code) and sequences the CSR updates a trap needs (mepc, mcause, mtval) over the CSR file's single write port.
- Issues a PC redirect to mtvec or mepc, or halts the core.
- Arbitrates the CSR read/write ports between itself and the datapath's csrrw/csrrs path.

Parameters:
- XLEN, 64, datapath/CSR width
- HALT_ON_ILLEGAL, 1, 1 = illegal instruction halts the core; 0 = illegal takes a trap with mcause 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  decode-stage instruction valid this cycle
- inst  in  32  raw instruction word
- pc  in  XLEN  PC of the decode-stage instruction
- is_ecall  in  1  decoded ecall
- is_ebreak  in  1  decoded ebreak
- is_mret  in  1  decoded mret
- unknown_code  in  1  decoder flags the instruction as illegal
- dp_csr_raddr  in  12  datapath CSR read address
- dp_csr_we  in  1  datapath CSR write enable (csrrw/csrrs)
- dp_csr_waddr  in  12  datapath CSR write address
- dp_csr_wdata  in  XLEN  datapath CSR write data
- csr_rdata  in  XLEN  CSR file combinational read data for csr_raddr
- csr_raddr  out  12  CSR file read address
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  XLEN  CSR file write data
- stall  out  1  freeze fetch/decode
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- halt  out  1  core halted (sticky)
- halt_code  out  2  01 = ebreak, 10 = illegal, 00 = running

Behaviour:
- Reset: state IDLE; csr_we, stall, redirect_valid, halt = 0; halt_code = 00; captured pc/inst/cause cleared. Reset in any state, including HALT, returns to IDLE the next cycle.
- Event selection: events are considered only when inst_valid = 1 and state = IDLE.
  - Priority: unknown_code > is_ebreak > is_ecall > is_mret.
  - Lower-priority flags asserted in the same cycle are ignored.
- Detection cycle (cycle 0):
  - stall = 1 combinationally in the same cycle.
  - Latch pc, inst and cause: ecall = 11; illegal = 2.
  - Datapath CSR write is dropped this cycle.
- States:
  - IDLE: csr_raddr = dp_csr_raddr; csr_we/waddr/wdata = dp_csr_*.
    - ebreak → HALT.
    - unknown with HALT_ON_ILLEGAL = 1 → HALT.
    - ecall, or unknown with HALT_ON_ILLEGAL = 0 → W_MEPC.
    - mret → RET.
  - W_MEPC: csr_we = 1, waddr = 0x341, wdata = latched pc → W_MCAUSE.
  - W_MCAUSE: csr_we = 1, waddr = 0x342, wdata = zero-extended cause → W_MTVAL.
  - W_MTVAL: csr_we = 1, waddr = 0x343, wdata = zero-extended inst for illegal, 0 for ecall → VEC.
  - VEC: csr_raddr = 0x305; redirect_valid = 1; redirect_pc = {csr_rdata[XLEN-1:2], 2'b00} (direct mode only) → IDLE.
  - RET: csr_raddr = 0x341; redirect_valid = 1; redirect_pc = {csr_rdata[XLEN-1:2], 2'b00} → IDLE.
  - HALT: halt = 1; halt_code = 01 (ebreak) or 10 (illegal); stall = 1 until rst; csr_we = 0.
- stall = 1 in every non-IDLE state, including VEC/RET. stall drops the cycle after the redirect.
- Latency:
  - ecall/illegal trap: 5 cycles from detection to the redirect strobe (cycles 1–3 writes, cycle 4 redirect).
  - mret: redirect on cycle 1.
  - halt: asserted cycle 1.
- Datapath CSR requests are ignored (not queued) in all non-IDLE states; the stall guarantees none are legitimate.
- In IDLE with inst_valid = 0, all decode flags are ignored.
- Port arbitration is exclusive: at most one of {datapath, sequencer} drives the write port in any cycle.

Decomposition:
- Shared package/header:
  - CSR addresses: MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343
  - cause codes: 2, 11
  - halt codes
  - state encoding
- Optional sub-module trap_evt_enc: combinational priority encoder turning flags into {event kind, cause}. Everything else lives in one FSM module.

Test Plan:
- ecall at pc = 0x8000_0010, mtvec = 0x8000_0100 → writes 0x341 = 0x8000_0010, 0x342 = 11, 0x343 = 0 on cycles 1–3; redirect_valid on cycle 4 with redirect_pc = 0x8000_0100; stall high cycles 0–4.
- mret with mepc = 0x8000_0013 → cycle 1 redirect_pc = 0x8000_0010; no csr_we; stall high cycles 0–1.
- ebreak → halt = 1, halt_code = 01 from cycle 1; holds across 10 cycles; rst pulse → halt = 0, state IDLE.
- Illegal inst = 0xFFFF_FFFF at pc = 0x8000_0020:
  - HALT_ON_ILLEGAL = 1 → halt_code = 10.
  - HALT_ON_ILLEGAL = 0 → mcause = 2, mtval = 0xFFFF_FFFF, redirect to mtvec.
- unknown_code and is_ecall high together → illegal path taken; dp_csr_we = 1 during W_MCAUSE → only the sequencer write reaches the CSR file; IDLE dp write to 0x300 passes through same-cycle.
- rst asserted during W_MCAUSE → next cycle IDLE, csr_we = 0, stall = 0, no redirect issued.

Source files
------------

// File: rtl/trap_seq_ctrl_pkg.sv
// Shared constants and encodings for the trap/return sequencer.
package trap_seq_ctrl_pkg;

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    // Trap cause codes (zero-extended to XLEN when written to mcause)
    localparam int CAUSE_W = 4;
    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL   = 4'd11;

    // Halt reason reported on halt_code
    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_ILLEGAL = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_VEC,
        ST_RET,
        ST_HALT
    } state_t;

    // Decoded event kinds, after priority resolution
    typedef enum logic [2:0] {
        EVT_NONE,
        EVT_ILLEGAL,
        EVT_EBREAK,
        EVT_ECALL,
        EVT_MRET
    } evt_kind_t;

endpackage

// File: rtl/trap_seq_ctrl_evt_enc.sv
// Priority encoder: decode flags -> {event kind, trap cause}.
// Priority is illegal > ebreak > ecall > mret; lower flags are dropped.
module trap_evt_enc
    import trap_seq_ctrl_pkg::*;
(
    input  logic               inst_valid,
    input  logic               unknown_code,
    input  logic               is_ebreak,
    input  logic               is_ecall,
    input  logic               is_mret,
    output evt_kind_t          evt_kind,
    output logic [CAUSE_W-1:0] evt_cause
);

    // Resolve the highest-priority flag; nothing is reported without a valid instruction
    always_comb begin
        evt_kind  = EVT_NONE;
        evt_cause = CAUSE_NONE;
        if (inst_valid) begin
            if (unknown_code) begin
                evt_kind  = EVT_ILLEGAL;
                evt_cause = CAUSE_ILLEGAL;
            end else if (is_ebreak) begin
                evt_kind  = EVT_EBREAK;
            end else if (is_ecall) begin
                evt_kind  = EVT_ECALL;
                evt_cause = CAUSE_ECALL;
            end else if (is_mret) begin
                evt_kind  = EVT_MRET;
            end
        end
    end

endmodule

// File: rtl/trap_seq_ctrl.sv
// Trap/return sequencer: walks mepc/mcause/mtval writes through the single
// CSR write port, redirects to mtvec or mepc, or halts the core. Owns the
// CSR ports outside IDLE; in IDLE the datapath passes straight through.
module trap_seq_ctrl
    import trap_seq_ctrl_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    input  logic            unknown_code,
    input  logic [11:0]     dp_csr_raddr,
    input  logic            dp_csr_we,
    input  logic [11:0]     dp_csr_waddr,
    input  logic [XLEN-1:0] dp_csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_raddr,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halt,
    output logic [1:0]      halt_code
);

    state_t             state_reg, state_next;
    logic [XLEN-1:0]    pc_reg;
    logic [31:0]        inst_reg;
    logic [CAUSE_W-1:0] cause_reg;
    logic [1:0]         halt_code_reg;

    evt_kind_t          evt_kind;
    logic [CAUSE_W-1:0] evt_cause;
    logic               evt_take;
    logic [XLEN-1:0]    rdata_aligned;
    logic               rdata_low_unused;

    trap_evt_enc u_evt_enc (
        .inst_valid   (inst_valid),
        .unknown_code (unknown_code),
        .is_ebreak    (is_ebreak),
        .is_ecall     (is_ecall),
        .is_mret      (is_mret),
        .evt_kind     (evt_kind),
        .evt_cause    (evt_cause)
    );

    // Events are only accepted while idle; later flags are ignored until we return
    assign evt_take = (state_reg == ST_IDLE) && (evt_kind != EVT_NONE);

    // Redirect targets are always word aligned (direct vectoring only)
    assign rdata_aligned    = {csr_rdata[XLEN-1:2], 2'b00};
    assign rdata_low_unused = ^csr_rdata[1:0];

    // State register plus capture of the trapping instruction's context
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            inst_reg      <= '0;
            cause_reg     <= CAUSE_NONE;
            halt_code_reg <= HALT_NONE;
        end else begin
            state_reg <= state_next;
            if (evt_take) begin
                pc_reg        <= pc;
                inst_reg      <= inst;
                cause_reg     <= evt_cause;
                halt_code_reg <= (evt_kind == EVT_EBREAK) ? HALT_EBREAK : HALT_ILLEGAL;
            end
        end
    end

    // Next-state and CSR-port / redirect / halt outputs
    always_comb begin
        state_next     = state_reg;
        csr_raddr      = dp_csr_raddr;
        csr_we         = 1'b0;
        csr_waddr      = dp_csr_waddr;
        csr_wdata      = dp_csr_wdata;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        halt_code      = HALT_NONE;

        case (state_reg)
            ST_IDLE: begin
                // Detection cycle freezes decode and drops the datapath write
                stall  = evt_take;
                csr_we = dp_csr_we && !evt_take;
                case (evt_kind)
                    EVT_ILLEGAL: state_next = HALT_ON_ILLEGAL ? ST_HALT : ST_W_MEPC;
                    EVT_EBREAK:  state_next = ST_HALT;
                    EVT_ECALL:   state_next = ST_W_MEPC;
                    EVT_MRET:    state_next = ST_RET;
                    default:     state_next = ST_IDLE;
                endcase
            end
            ST_W_MEPC: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_MEPC;
                csr_wdata  = pc_reg;
                state_next = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_we     = 1'b1;
                csr_waddr  = CSR_MCAUSE;
                csr_wdata  = XLEN'(cause_reg);
                state_next = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                // mtval carries the offending encoding only for illegal instructions
                csr_we     = 1'b1;
                csr_waddr  = CSR_MTVAL;
                csr_wdata  = (cause_reg == CAUSE_ILLEGAL) ? XLEN'(inst_reg) : '0;
                state_next = ST_VEC;
            end
            ST_VEC: begin
                csr_raddr      = CSR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = rdata_aligned;
                state_next     = ST_IDLE;
            end
            ST_RET: begin
                csr_raddr      = CSR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = rdata_aligned;
                state_next     = ST_IDLE;
            end
            ST_HALT: begin
                // Sticky until reset
                halt      = 1'b1;
                halt_code = halt_code_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Self-checking bench for trap_seq_ctrl: one instance per HALT_ON_ILLEGAL
// setting, directed vector table, randomized transactions checked against a
// per-cycle behavioural model, and a reset-mid-trap sequence.
module tb_trap_seq_ctrl;
    import trap_seq_ctrl_pkg::*;

    localparam int XLEN = 64;

    // Event kinds as seen by the reference model
    localparam int K_NONE       = 0;
    localparam int K_HALT_EBK   = 1;
    localparam int K_HALT_ILL   = 2;
    localparam int K_TRAP_ECALL = 3;
    localparam int K_TRAP_ILL   = 4;
    localparam int K_MRET       = 5;

    typedef struct packed {
        logic        valid;
        logic [3:0]  flags;      // {unknown_code, is_ebreak, is_ecall, is_mret}
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        logic        dp_we;
        logic [11:0] dp_waddr;
        logic [63:0] dp_wdata;
    } txn_t;

    typedef struct packed {
        logic        stall;
        logic        we;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        rv;
        logic [63:0] rpc;
        logic        halt;
        logic [1:0]  hcode;
        logic        raddr_dp;   // csr_raddr must follow dp_csr_raddr
    } exp_t;

    typedef struct packed {
        txn_t        t;
        logic [63:0] exp_rpc_h;
        logic [63:0] exp_rpc_t;
        logic [1:0]  exp_hcode_h;
        logic [1:0]  exp_hcode_t;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            is_ecall, is_ebreak, is_mret, unknown_code;
    logic [11:0]     dp_csr_raddr, dp_csr_waddr;
    logic            dp_csr_we;
    logic [XLEN-1:0] dp_csr_wdata;
    logic [XLEN-1:0] mtvec_v, mepc_v;

    logic [XLEN-1:0] csr_rdata_h, csr_rdata_t;
    logic [11:0]     csr_raddr_h, csr_raddr_t, csr_waddr_h, csr_waddr_t;
    logic            csr_we_h, csr_we_t, stall_h, stall_t;
    logic [XLEN-1:0] csr_wdata_h, csr_wdata_t, redirect_pc_h, redirect_pc_t;
    logic            redirect_valid_h, redirect_valid_t, halt_h, halt_t;
    logic [1:0]      halt_code_h, halt_code_t;

    // Minimal CSR file view: mtvec and mepc come from the bench, others are a fixed pattern
    assign csr_rdata_h = (csr_raddr_h == CSR_MTVEC) ? mtvec_v :
                         (csr_raddr_h == CSR_MEPC)  ? mepc_v  :
                         ({52'h0, csr_raddr_h} ^ 64'hDEAD_BEEF_0000_0000);
    assign csr_rdata_t = (csr_raddr_t == CSR_MTVEC) ? mtvec_v :
                         (csr_raddr_t == CSR_MEPC)  ? mepc_v  :
                         ({52'h0, csr_raddr_t} ^ 64'hDEAD_BEEF_0000_0000);

    trap_seq_ctrl #(.XLEN(XLEN), .HALT_ON_ILLEGAL(1'b1)) u_dut_h (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .unknown_code(unknown_code), .dp_csr_raddr(dp_csr_raddr),
        .dp_csr_we(dp_csr_we), .dp_csr_waddr(dp_csr_waddr),
        .dp_csr_wdata(dp_csr_wdata), .csr_rdata(csr_rdata_h),
        .csr_raddr(csr_raddr_h), .csr_we(csr_we_h), .csr_waddr(csr_waddr_h),
        .csr_wdata(csr_wdata_h), .stall(stall_h),
        .redirect_valid(redirect_valid_h), .redirect_pc(redirect_pc_h),
        .halt(halt_h), .halt_code(halt_code_h)
    );

    trap_seq_ctrl #(.XLEN(XLEN), .HALT_ON_ILLEGAL(1'b0)) u_dut_t (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .unknown_code(unknown_code), .dp_csr_raddr(dp_csr_raddr),
        .dp_csr_we(dp_csr_we), .dp_csr_waddr(dp_csr_waddr),
        .dp_csr_wdata(dp_csr_wdata), .csr_rdata(csr_rdata_t),
        .csr_raddr(csr_raddr_t), .csr_we(csr_we_t), .csr_waddr(csr_waddr_t),
        .csr_wdata(csr_wdata_t), .stall(stall_t),
        .redirect_valid(redirect_valid_t), .redirect_pc(redirect_pc_t),
        .halt(halt_t), .halt_code(halt_code_t)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] obs_rpc_h, obs_rpc_t;
    logic [1:0]  obs_hcode_h, obs_hcode_t;

    // ---------------- reference model ----------------
    function automatic int kind_of(input txn_t t, input bit hoi);
        if (!t.valid)   return K_NONE;
        if (t.flags[3]) return hoi ? K_HALT_ILL : K_TRAP_ILL;
        if (t.flags[2]) return K_HALT_EBK;
        if (t.flags[1]) return K_TRAP_ECALL;
        if (t.flags[0]) return K_MRET;
        return K_NONE;
    endfunction

    function automatic int kind_len(input int kd);
        case (kd)
            K_HALT_EBK, K_HALT_ILL:   return 11;
            K_TRAP_ECALL, K_TRAP_ILL: return 6;
            K_MRET:                   return 3;
            default:                  return 1;
        endcase
    endfunction

    function automatic exp_t exp_idle();
        exp_t e;
        e = '0;
        e.raddr_dp = 1'b1;
        return e;
    endfunction

    // Expected outputs k cycles after the event is presented (k = 0 is detection)
    function automatic exp_t model_at(input txn_t t, input bit hoi, input int k);
        exp_t e;
        int   kd;
        kd = kind_of(t, hoi);
        e  = exp_idle();
        if (k == 0) begin
            if (kd == K_NONE) begin
                e.we    = t.dp_we;
                e.waddr = t.dp_waddr;
                e.wdata = t.dp_wdata;
            end else begin
                e.stall = 1'b1;
            end
            return e;
        end
        case (kd)
            K_HALT_EBK, K_HALT_ILL: begin
                e = '0;
                e.stall = 1'b1;
                e.halt  = 1'b1;
                e.hcode = (kd == K_HALT_EBK) ? 2'b01 : 2'b10;
            end
            K_TRAP_ECALL, K_TRAP_ILL: begin
                if (k <= 4) begin
                    e = '0;
                    e.stall = 1'b1;
                end
                case (k)
                    1: begin e.we = 1'b1; e.waddr = 12'h341; e.wdata = t.pc; end
                    2: begin e.we = 1'b1; e.waddr = 12'h342; e.wdata = (kd == K_TRAP_ECALL) ? 64'd11 : 64'd2; end
                    3: begin e.we = 1'b1; e.waddr = 12'h343; e.wdata = (kd == K_TRAP_ILL) ? {32'h0, t.inst} : 64'h0; end
                    4: begin e.rv = 1'b1; e.rpc = t.mtvec & ~64'h3; end
                    default: ;
                endcase
            end
            K_MRET: begin
                if (k == 1) begin
                    e = '0;
                    e.stall = 1'b1;
                    e.rv    = 1'b1;
                    e.rpc   = t.mepc & ~64'h3;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- drive / sample / compare ----------------
    function automatic txn_t mk_txn(input logic v, input logic [3:0] f, input logic [63:0] p,
                                    input logic [31:0] i, input logic [63:0] tv, input logic [63:0] ep,
                                    input logic we, input logic [11:0] wa, input logic [63:0] wd);
        txn_t t;
        t.valid = v; t.flags = f; t.pc = p; t.inst = i; t.mtvec = tv; t.mepc = ep;
        t.dp_we = we; t.dp_waddr = wa; t.dp_wdata = wd;
        return t;
    endfunction

    task automatic drive_quiet();
        inst_valid   = 1'b0;
        {unknown_code, is_ebreak, is_ecall, is_mret} = 4'($urandom_range(0, 15));
        pc           = {$urandom, $urandom};
        inst         = $urandom;
        dp_csr_we    = 1'b0;
        dp_csr_raddr = 12'($urandom_range(0, 4095));
        dp_csr_waddr = 12'($urandom_range(0, 4095));
        dp_csr_wdata = {$urandom, $urandom};
    endtask

    // Flags and datapath writes that a stalled sequencer must ignore
    task automatic drive_junk();
        drive_quiet();
        inst_valid = 1'b1;
        dp_csr_we  = 1'b1;
    endtask

    task automatic drive_event(input txn_t t);
        inst_valid   = t.valid;
        {unknown_code, is_ebreak, is_ecall, is_mret} = t.flags;
        pc           = t.pc;
        inst         = t.inst;
        dp_csr_we    = t.dp_we;
        dp_csr_waddr = t.dp_waddr;
        dp_csr_wdata = t.dp_wdata;
        dp_csr_raddr = 12'($urandom_range(0, 4095));
    endtask

    function automatic exp_t obs_h();
        exp_t a;
        a = '0;
        a.stall = stall_h; a.we = csr_we_h; a.waddr = csr_waddr_h; a.wdata = csr_wdata_h;
        a.rv = redirect_valid_h; a.rpc = redirect_pc_h; a.halt = halt_h; a.hcode = halt_code_h;
        a.raddr_dp = (csr_raddr_h == dp_csr_raddr);
        return a;
    endfunction

    function automatic exp_t obs_t();
        exp_t a;
        a = '0;
        a.stall = stall_t; a.we = csr_we_t; a.waddr = csr_waddr_t; a.wdata = csr_wdata_t;
        a.rv = redirect_valid_t; a.rpc = redirect_pc_t; a.halt = halt_t; a.hcode = halt_code_t;
        a.raddr_dp = (csr_raddr_t == dp_csr_raddr);
        return a;
    endfunction

    task automatic check(input string name, input exp_t e, input exp_t a);
        bit ok;
        ok = 1'b1;
        n_cmp++;
        if (a.stall !== e.stall || a.we !== e.we || a.rv !== e.rv) ok = 1'b0;
        if (a.halt !== e.halt || a.hcode !== e.hcode) ok = 1'b0;
        if (e.we && (a.waddr !== e.waddr || a.wdata !== e.wdata)) ok = 1'b0;
        if (e.rv && a.rpc !== e.rpc) ok = 1'b0;
        if (e.raddr_dp && a.raddr_dp !== 1'b1) ok = 1'b0;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got stall=%0b we=%0b waddr=%h wdata=%h rv=%0b rpc=%h halt=%0b code=%b raddr_follow=%0b | want stall=%0b we=%0b waddr=%h wdata=%h rv=%0b rpc=%h halt=%0b code=%b raddr_follow=%0b",
                     name, a.stall, a.we, a.waddr, a.wdata, a.rv, a.rpc, a.halt, a.hcode, a.raddr_dp,
                     e.stall, e.we, e.waddr, e.wdata, e.rv, e.rpc, e.halt, e.hcode, e.raddr_dp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Play one transaction on both instances and compare every cycle
    task automatic run_txn(input int id, input txn_t t);
        int   len, la, lb;
        exp_t eh, et;
        la  = kind_len(kind_of(t, 1'b1));
        lb  = kind_len(kind_of(t, 1'b0));
        len = (la > lb) ? la : lb;
        mtvec_v = t.mtvec;
        mepc_v  = t.mepc;
        obs_rpc_h = '0; obs_rpc_t = '0; obs_hcode_h = '0; obs_hcode_t = '0;
        for (int k = 0; k < len; k++) begin
            eh = model_at(t, 1'b1, k);
            et = model_at(t, 1'b0, k);
            if (k == 0)                    drive_event(t);
            else if (eh.stall && et.stall) drive_junk();
            else                           drive_quiet();
            @(negedge clk);
            check($sformatf("txn%0d.H.c%0d", id, k), eh, obs_h());
            check($sformatf("txn%0d.T.c%0d", id, k), et, obs_t());
            if (redirect_valid_h) obs_rpc_h = redirect_pc_h;
            if (redirect_valid_t) obs_rpc_t = redirect_pc_t;
            if (halt_h) obs_hcode_h = halt_code_h;
            if (halt_t) obs_hcode_t = halt_code_t;
            @(posedge clk); #1;
        end
        if (la == 11 || lb == 11) begin
            rst = 1'b1;
            drive_quiet();
            @(posedge clk); #1;
            rst = 1'b0;
        end
        drive_quiet();
        @(negedge clk);
        check($sformatf("txn%0d.H.post", id), exp_idle(), obs_h());
        check($sformatf("txn%0d.T.post", id), exp_idle(), obs_t());
        @(posedge clk); #1;
        $display("txn %0d: valid=%0b flags=%b pc=%h cycles=%0d", id, t.valid, t.flags, t.pc, len);
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        exp_t e;

        // Directed vectors: inputs plus hand-computed redirect / halt results
        vecs[0] = '{t: mk_txn(1, 4'b0010, 64'h8000_0010, 32'h0000_0073, 64'h8000_0100, 64'h0, 1, 12'h300, 64'h55),
                    exp_rpc_h: 64'h8000_0100, exp_rpc_t: 64'h8000_0100, exp_hcode_h: 2'b00, exp_hcode_t: 2'b00};
        vecs[1] = '{t: mk_txn(1, 4'b0001, 64'h8000_0040, 32'h3020_0073, 64'h8000_0100, 64'h8000_0013, 0, 12'h0, 64'h0),
                    exp_rpc_h: 64'h8000_0010, exp_rpc_t: 64'h8000_0010, exp_hcode_h: 2'b00, exp_hcode_t: 2'b00};
        vecs[2] = '{t: mk_txn(1, 4'b0100, 64'h8000_0050, 32'h0010_0073, 64'h8000_0100, 64'h0, 0, 12'h0, 64'h0),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h0, exp_hcode_h: 2'b01, exp_hcode_t: 2'b01};
        vecs[3] = '{t: mk_txn(1, 4'b1000, 64'h8000_0020, 32'hFFFF_FFFF, 64'h8000_0100, 64'h0, 0, 12'h0, 64'h0),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h8000_0100, exp_hcode_h: 2'b10, exp_hcode_t: 2'b00};
        vecs[4] = '{t: mk_txn(1, 4'b1010, 64'h8000_0020, 32'hFFFF_FFFF, 64'h8000_0100, 64'h0, 1, 12'h342, 64'h77),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h8000_0100, exp_hcode_h: 2'b10, exp_hcode_t: 2'b00};
        vecs[5] = '{t: mk_txn(1, 4'b0000, 64'h8000_0060, 32'h0000_0013, 64'h8000_0100, 64'h0, 1, 12'h300, 64'h1234),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h0, exp_hcode_h: 2'b00, exp_hcode_t: 2'b00};
        vecs[6] = '{t: mk_txn(1, 4'b0011, 64'h8000_0070, 32'h0000_0073, 64'h8000_0203, 64'h9000_0000, 0, 12'h0, 64'h0),
                    exp_rpc_h: 64'h8000_0200, exp_rpc_t: 64'h8000_0200, exp_hcode_h: 2'b00, exp_hcode_t: 2'b00};
        vecs[7] = '{t: mk_txn(1, 4'b0111, 64'h8000_0080, 32'h0010_0073, 64'h8000_0100, 64'h8000_0000, 0, 12'h0, 64'h0),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h0, exp_hcode_h: 2'b01, exp_hcode_t: 2'b01};
        vecs[8] = '{t: mk_txn(0, 4'b0100, 64'h8000_0090, 32'h0010_0073, 64'h8000_0100, 64'h0, 1, 12'h300, 64'hABCD),
                    exp_rpc_h: 64'h0, exp_rpc_t: 64'h0, exp_hcode_h: 2'b00, exp_hcode_t: 2'b00};

        // Reset and check the reset state
        rst = 1'b1;
        mtvec_v = '0;
        mepc_v  = '0;
        drive_quiet();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_quiet();
        @(negedge clk);
        check("reset.H", exp_idle(), obs_h());
        check("reset.T", exp_idle(), obs_t());
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i].t);
            check_val($sformatf("vec%0d.rpc_h", i),   obs_rpc_h,           vecs[i].exp_rpc_h);
            check_val($sformatf("vec%0d.rpc_t", i),   obs_rpc_t,           vecs[i].exp_rpc_t);
            check_val($sformatf("vec%0d.hcode_h", i), {62'h0, obs_hcode_h}, {62'h0, vecs[i].exp_hcode_h});
            check_val($sformatf("vec%0d.hcode_t", i), {62'h0, obs_hcode_t}, {62'h0, vecs[i].exp_hcode_t});
        end

        // Reset asserted while the mcause write is on the port: no redirect may follow
        t = mk_txn(1, 4'b0010, 64'h8000_0010, 32'h0000_0073, 64'h8000_0100, 64'h0, 0, 12'h0, 64'h0);
        mtvec_v = t.mtvec;
        drive_event(t);
        @(negedge clk);
        check("rstmid.c0", model_at(t, 1'b0, 0), obs_t());
        @(posedge clk); #1;
        drive_junk();
        @(negedge clk);
        check("rstmid.c1", model_at(t, 1'b0, 1), obs_t());
        @(posedge clk); #1;
        drive_junk();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.c2", model_at(t, 1'b0, 2), obs_t());
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_quiet();
            @(negedge clk);
            e = exp_idle();
            check($sformatf("rstmid.after%0d.T", k), e, obs_t());
            check($sformatf("rstmid.after%0d.H", k), e, obs_h());
            @(posedge clk); #1;
        end

        // Randomized transactions against the model
        for (int i = 0; i < 150; i++) begin
            t = mk_txn(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
                       {$urandom, $urandom}, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), {$urandom, $urandom});
            run_txn(100 + i, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
